// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the NeoPixel serial transmitter.
package neopixel_pkg;

    localparam int PIX_W = 24;
    localparam int CNT_W = 12;
    localparam int IDX_W = 5;

    // Defaults assume a 50 MHz ACLK
    localparam int DEF_T0H_CYCLES    = 20;
    localparam int DEF_T1H_CYCLES    = 40;
    localparam int DEF_TBIT_CYCLES   = 63;
    localparam int DEF_TLATCH_CYCLES = 2800;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

endpackage

// File: rtl/neopixel_tx.sv
// Serialises 24-bit GRB pixels onto a single-wire NeoPixel line with back-to-back
// pixel chaining, end-of-frame latch time, and underrun detection.
//
// state | meaning
// IDLE  | line low, waiting for the first pixel of a frame
// HIGH  | high part of the current bit (T0H or T1H cycles)
// LOW   | low remainder of the bit; at its end shift, chain, latch or underrun
// LATCH | line held low for the latch time, then done pulses
module neopixel_tx
    import neopixel_pkg::*;
#(
    parameter int T0H_CYCLES    = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES    = DEF_T1H_CYCLES,
    parameter int TBIT_CYCLES   = DEF_TBIT_CYCLES,
    parameter int TLATCH_CYCLES = DEF_TLATCH_CYCLES
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_last,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < TBIT_CYCLES &&
          TBIT_CYCLES <= 4095 && TLATCH_CYCLES >= 1 && TLATCH_CYCLES <= 4095)) begin : g_bad_timing
        $error("neopixel_tx: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] T0H_END    = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_END    = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] TBIT_END   = CNT_W'(TBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TLATCH_END = CNT_W'(TLATCH_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [PIX_W-1:0]   shift;
    logic               last;
    logic               take;
    logic [CNT_W-1:0]   high_end;

    // Ready only when a new pixel can start on the very next bit slot
    assign pix_ready = !ARESET &&
                       ((state == IDLE) ||
                        (state == LOW && idx == '0 && cnt == TBIT_END && !last));
    assign take      = pix_valid && pix_ready;
    assign high_end  = shift[PIX_W-1] ? T1H_END : T0H_END;
    assign busy      = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            last     <= 1'b0;
            dout     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (take) begin
                shift <= pix_data;
                last  <= pix_last;
                idx   <= IDX_W'(PIX_W - 1);
                cnt   <= '0;
                state <= HIGH;
                dout  <= 1'b1;
            end else begin
                case (state)
                    HIGH: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == high_end) begin
                            state <= LOW;
                            dout  <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (cnt == TBIT_END) begin
                            cnt <= '0;
                            if (idx != '0) begin
                                shift <= {shift[PIX_W-2:0], 1'b0};
                                idx   <= idx - 1'b1;
                                state <= HIGH;
                                dout  <= 1'b1;
                            end else if (last) begin
                                state <= LATCH;
                            end else begin
                                underrun <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LATCH: begin
                        if (cnt == TLATCH_END) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neopixel_tx.sv
// Scoreboard bench for neopixel_tx: a line decoder rebuilds pixels from dout
// pulse widths and compares them with the pixels handed to the DUT.
module tb_neopixel_tx;
    import neopixel_pkg::*;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TLATCH = 2800;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready, dout, busy, done, underrun;

    neopixel_tx #(
        .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .TBIT_CYCLES(TBIT), .TLATCH_CYCLES(TLATCH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last), .dout(dout), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int n_done = 0, n_under = 0, n_pix = 0;
    int done_cyc = 0, under_cyc = 0, last_rise = 0;
    int hi_len = 0, bits = 0;
    bit have_rise = 0;
    logic prev_dout = 1'b0;
    logic [23:0] acc_pix = '0;
    logic [23:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: bit value from high width, pixel boundaries every 24 bits
    always @(negedge ACLK) begin
        logic [23:0] e;
        if (ARESET) begin
            bits = 0; have_rise = 0; hi_len = 0; prev_dout = 1'b0;
            exp_q.delete();
        end else begin
            if (dout && !prev_dout) begin
                if (have_rise) check_val("bit_period", cyc - last_rise, TBIT);
                have_rise = 1; last_rise = cyc; hi_len = 1;
            end else if (dout) begin
                hi_len++;
            end else if (prev_dout) begin
                check_val("high_width", hi_len, (hi_len == T1H) ? T1H : T0H);
                check_val("busy_in_frame", busy, 1);
                acc_pix = {acc_pix[22:0], (hi_len == T1H)};
                bits++;
                if (bits == 24) begin
                    bits = 0;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_pixel", acc_pix, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("pixel", acc_pix, e);
                        n_pix++;
                    end
                end
            end
            if (done) begin
                n_done++; done_cyc = cyc; have_rise = 0;
                check_val("done_on_boundary", bits, 0);
            end
            if (underrun) begin
                n_under++; under_cyc = cyc; have_rise = 0;
            end
            prev_dout = dout;
        end
    end

    // Called at a negedge; returns at the negedge right after the transfer edge
    task automatic send_pixel(input logic [23:0] d, input logic l, output int acc);
        int budget = 6000;
        pix_valid = 1'b1; pix_data = d; pix_last = l;
        while (!pix_ready && budget > 0) begin
            @(negedge ACLK);
            budget--;
        end
        acc = cyc;
        if (budget == 0) begin
            check_val("accept_timeout", 0, 1);
            pix_valid = 1'b0;
            return;
        end
        exp_q.push_back(d);
        @(negedge ACLK);
        pix_valid = 1'b0; pix_data = 24'($urandom); pix_last = 1'($urandom);
        check_val("start_latency", dout, 1);
        check_val("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int d0 = n_done;
        int budget = 8000;
        while (n_done == d0 && budget > 0) begin
            @(negedge ACLK);
            budget--;
        end
        if (n_done == d0) check_val({tag, "_timeout"}, 0, 1);
        repeat (3) @(negedge ACLK);
        check_val({tag, "_done_once"}, n_done, d0 + 1);
        check_val({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int a1, a2, d0, u0, p0, budget;

        repeat (3) @(negedge ACLK);
        check_val("rst_dout", dout, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_ready", pix_ready, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("idle_ready", pix_ready, 1);

        // single pixel, MSB set: one long pulse then 23 short ones, then latch
        p0 = n_pix;
        send_pixel(24'h800000, 1'b1, a1);
        wait_done("single");
        check_val("latch_time", done_cyc - last_rise, TBIT - 1 + TLATCH + 1);
        check_val("single_pix_count", n_pix - p0, 1);

        // two pixels back to back with valid held
        p0 = n_pix;
        send_pixel(24'hFFFFFF, 1'b0, a1);
        send_pixel(24'h000000, 1'b1, a2);
        check_val("chain_spacing", a2 - a1, 24 * TBIT);
        wait_done("chain");
        check_val("chain_pix_count", n_pix - p0, 2);

        // starvation after a non-final pixel
        d0 = n_done; u0 = n_under;
        send_pixel(24'h00FF00, 1'b0, a1);
        budget = 3000;
        while (n_under == u0 && budget > 0) begin
            @(negedge ACLK);
            budget--;
        end
        repeat (2) @(negedge ACLK);
        check_val("underrun_once", n_under, u0 + 1);
        check_val("underrun_time", under_cyc - a1, 24 * TBIT + 1);
        check_val("underrun_busy", busy, 0);
        check_val("underrun_ready", pix_ready, 1);
        check_val("underrun_no_done", n_done, d0);

        // reset 100 cycles into a frame
        d0 = n_done; u0 = n_under;
        send_pixel(24'($urandom), 1'b1, a1);
        repeat (99) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_val("abort_dout", dout, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_ready_in_rst", pix_ready, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("abort_ready", pix_ready, 1);
        repeat (200) @(negedge ACLK);
        check_val("abort_no_done", n_done, d0);
        check_val("abort_no_underrun", n_under, u0);
        check_val("abort_dout_quiet", dout, 0);

        // pixel offered during latch must wait for IDLE
        send_pixel(24'h5A3C96, 1'b1, a1);
        send_pixel(24'hA5C369, 1'b1, a2);
        check_val("latch_accept_cycle", a2, done_cyc);
        wait_done("latch_hold");

        // random stream, last on the final pixel
        p0 = n_pix;
        for (int i = 0; i < 5; i++) send_pixel(24'($urandom), (i == 4), a1);
        wait_done("stream");
        check_val("stream_pix_count", n_pix - p0, 5);
        check_val("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neopixel_tx.md
NEOPIXEL_TX -- requirements
Module: neopixel_tx

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 20: high time of a '0' bit in ACLK cycles (0.40 us at 50 MHz).
REQ-002 SHALL have parameter T1H_CYCLES, default 40: high time of a '1' bit in ACLK cycles (0.80 us).
REQ-003 SHALL have parameter TBIT_CYCLES, default 63: total bit period in ACLK cycles (1.26 us).
REQ-004 SHALL have parameter TLATCH_CYCLES, default 2800: low latch time after a frame (56 us).
REQ-005 SHALL have ports ACLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have ports ARESET, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports pix_data, input, 24: pixel as {G[7:0],R[7:0],B[7:0]}.
REQ-008 SHALL have ports pix_valid / pix_ready, input / output, 1 each: pixel handshake.
REQ-009 SHALL have ports pix_last, input, 1: the pixel is the final pixel of the frame; sampled with pix_data.
REQ-010 SHALL have ports dout, output, 1: registered serial line to the LED strip.
REQ-011 SHALL have ports busy, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have ports done, output, 1: one-cycle pulse at frame completion; this is the interrupt source.
REQ-013 SHALL have ports underrun, output, 1: one-cycle pulse when the pixel stream starves mid-frame.

Function
REQ-014 SHALL have states IDLE, HIGH, LOW, LATCH; a 12-bit phase counter cnt; a 5-bit bit index idx; a 24-bit shift register; and a last flag.
REQ-015 A transfer SHALL occur on a cycle where pix_valid and pix_ready are both 1; pix_ready SHALL be combinational from state, cnt, idx and last only, never from pix_valid.
REQ-016 pix_ready SHALL be 1 in IDLE.
REQ-017 pix_ready SHALL also be 1 in LOW when idx==0, cnt==TBIT_CYCLES-1 and last==0; it SHALL be 0 otherwise.
REQ-018 On a transfer, the block SHALL load shift<=pix_data, last<=pix_last, idx<=23, cnt<=0, and state<=HIGH; dout SHALL be 1 on the next cycle, giving 1-cycle latency.
REQ-019 Bits SHALL be sent MSB first (bit 23 first).
REQ-020 HIGH SHALL hold for T0H_CYCLES when the current bit is 0, or T1H_CYCLES when it is 1, then go to LOW.
REQ-021 LOW SHALL last until cnt reaches TBIT_CYCLES-1, with cnt counted from the start of the bit, so each bit is exactly TBIT_CYCLES cycles.
REQ-022 At the end of LOW with idx>0, the block SHALL shift left, decrement idx, and return to HIGH.
REQ-023 At the end of LOW with idx==0 and last==1, the block SHALL go to LATCH with cnt<=0.
REQ-024 At the end of LOW with idx==0, last==0 and a transfer, the block SHALL load the next pixel with no gap, continuous with the bit timing.
REQ-025 At the end of LOW with idx==0, last==0 and no transfer, the block SHALL pulse underrun, go to IDLE with dout=0, and SHALL NOT pulse done.
REQ-026 dout SHALL be 1 only in HIGH.
REQ-027 In LATCH, dout SHALL be 0 for TLATCH_CYCLES cycles; then done SHALL pulse for 1 cycle and the state SHALL go to IDLE in the same cycle.
REQ-028 A pixel offered during LATCH SHALL wait (pix_ready=0) and SHALL be accepted in IDLE on the next cycle.
REQ-029 pix_data and pix_last SHALL be ignored when no transfer occurs.
REQ-030 The design SHALL require T0H_CYCLES < T1H_CYCLES < TBIT_CYCLES <= 4095 and TLATCH_CYCLES <= 4095; violations SHALL be reported at elaboration.

Reset
REQ-031 When ARESET=1 at a rising edge of ACLK, the block SHALL set state=IDLE, dout=0, busy=0, done=0, underrun=0, and cnt, idx, shift and last to 0.
REQ-032 Reset mid-frame SHALL abort immediately, with no done and no underrun.
REQ-033 pix_ready SHALL be 0 while ARESET=1.

Structure
REQ-034 Package neopixel_pkg SHALL hold the state enum, default timing constants, and the pixel width (24).
REQ-035 There SHALL be no sub-module; the counter and shifter are inline in one FSM block.
REQ-036 done SHALL drive the interrupt controller's bit-0 input directly.

Verification
REQ-037 Single pixel 0x800000 with last=1 -> dout high for 40 cycles, low 23; then 23 bits each high 20, low 43; then 2800 low; then done pulses once.
REQ-038 Two pixels 0xFFFFFF then 0x000000 (last on the second), valid held -> second pixel accepted exactly 24*63 cycles after the first; no gap; 48 bits total.
REQ-039 First pixel 0x00FF00 with last=0, valid dropped afterward -> underrun pulses 1512 cycles after acceptance; state returns to IDLE; done stays 0.
REQ-040 ARESET asserted 100 cycles into a frame -> next cycle dout=0, busy=0, pix_ready=1 after release, no done.
REQ-041 pix_valid held during LATCH -> pix_ready=0 throughout; accepted the cycle after done; dout rises 1 cycle later.
REQ-042 Random pixel stream -> a bench decoder reconstructs every pixel; busy=1 from acceptance to done.
